// File: rtl/vend_core_param.sv
// vend_core_param: parametrised vending controller core with credit, price lookup,
// per-slot stock, dispense pulses and coin-by-coin change over valid/ready.
//
// state  | meaning
// IDLE   | accept coins, selections, cancel and restock
// SHOW   | underfunded selection, price displayed for SHOW_CYCLES cycles
// CHANGE | return credit one greedy coin at a time
module vend_core_param #(
    parameter int N_SLOTS     = 9,
    parameter int CREDIT_W    = 12,
    parameter int MAX_CREDIT  = 2000,
    parameter int STOCK_W     = 4,
    parameter int STOCK_INIT  = 5,
    parameter int SHOW_CYCLES = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_SLOTS-1:0]          sel,
    input  logic [5:0]                  coin,
    input  logic                        cancel,
    input  logic                        restock,
    input  logic [N_SLOTS*CREDIT_W-1:0] price_flat,
    input  logic                        change_ready,
    output logic                        change_valid,
    output logic [5:0]                  change_coin,
    output logic [N_SLOTS-1:0]          dispense,
    output logic [N_SLOTS-1:0]          led_green,
    output logic [N_SLOTS-1:0]          led_red,
    output logic                        coin_reject,
    output logic [CREDIT_W-1:0]         credit,
    output logic [CREDIT_W-1:0]         disp_value
);
    localparam int IDX_W  = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam int SHOW_W = $clog2(SHOW_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SHOW, CHANGE} stateType;

    stateType            state, nextState;
    logic [STOCK_W-1:0]  stock [N_SLOTS];
    logic [CREDIT_W-1:0] price [N_SLOTS];
    logic [SHOW_W-1:0]   showCnt, nextShowCnt;
    logic [CREDIT_W-1:0] showPrice, nextShowPrice, nextCredit;
    logic [IDX_W-1:0]    selIdx;
    logic [CREDIT_W-1:0] coinVal, changeVal, creditLeft, creditPaid, dispNext;
    logic [CREDIT_W:0]   coinSum;
    logic [N_SLOTS-1:0]  vendNext, greenNext, redNext;
    logic                rejectNext, restockNow, changeValidNext;
    logic [5:0]          changeCoinNext;

    function automatic logic [CREDIT_W-1:0] coinValue(input logic [5:0] c);
        case (c)
            6'b000001: return CREDIT_W'(5);
            6'b000010: return CREDIT_W'(10);
            6'b000100: return CREDIT_W'(25);
            6'b001000: return CREDIT_W'(50);
            6'b010000: return CREDIT_W'(100);
            6'b100000: return CREDIT_W'(500);
            default:   return '0;
        endcase
    endfunction

    // Credit is always a multiple of 5, so the 5c fallback never leaves a remainder.
    function automatic logic [5:0] greedyCoin(input logic [CREDIT_W-1:0] c);
        if (c >= CREDIT_W'(500)) return 6'b100000;
        if (c >= CREDIT_W'(100)) return 6'b010000;
        if (c >= CREDIT_W'(50))  return 6'b001000;
        if (c >= CREDIT_W'(25))  return 6'b000100;
        if (c >= CREDIT_W'(10))  return 6'b000010;
        return 6'b000001;
    endfunction

    for (genvar g = 0; g < N_SLOTS; g++) begin : gPrice
        assign price[g] = price_flat[g*CREDIT_W +: CREDIT_W];
    end

    always_comb begin
        selIdx = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (sel[i]) selIdx = IDX_W'(i);
        end
    end

    assign coinVal    = coinValue(coin);
    assign coinSum    = {1'b0, credit} + {1'b0, coinVal};
    assign changeVal  = coinValue(change_coin);
    assign creditLeft = credit - price[selIdx];
    assign creditPaid = credit - changeVal;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            credit       <= '0;
            showCnt      <= '0;
            showPrice    <= '0;
            for (int i = 0; i < N_SLOTS; i++) stock[i] <= STOCK_W'(STOCK_INIT);
            dispense     <= '0;
            coin_reject  <= 1'b0;
            change_valid <= 1'b0;
            change_coin  <= '0;
            disp_value   <= '0;
            led_green    <= '0;
            led_red      <= '0;
        end else begin
            state     <= nextState;
            credit    <= nextCredit;
            showCnt   <= nextShowCnt;
            showPrice <= nextShowPrice;
            for (int i = 0; i < N_SLOTS; i++) begin
                if (restockNow)       stock[i] <= STOCK_W'(STOCK_INIT);
                else if (vendNext[i]) stock[i] <= stock[i] - STOCK_W'(1);
            end
            dispense     <= vendNext;
            coin_reject  <= rejectNext;
            change_valid <= changeValidNext;
            change_coin  <= changeCoinNext;
            disp_value   <= dispNext;
            led_green    <= greenNext;
            led_red      <= redNext;
        end
    end

    always_comb begin
        nextState     = state;
        nextCredit    = credit;
        nextShowCnt   = showCnt;
        nextShowPrice = showPrice;
        vendNext      = '0;
        rejectNext    = 1'b0;
        restockNow    = 1'b0;
        case (state)
            IDLE: begin
                if (cancel) begin
                    if (credit != '0) nextState = CHANGE;
                end else if (coin != '0) begin
                    if ($onehot(coin) && coinSum <= (CREDIT_W+1)'(MAX_CREDIT))
                        nextCredit = credit + coinVal;
                    else
                        rejectNext = 1'b1;
                end else if (sel != '0) begin
                    if ($onehot(sel) && stock[selIdx] != '0) begin
                        if (credit < price[selIdx]) begin
                            nextState     = SHOW;
                            nextShowCnt   = SHOW_W'(SHOW_CYCLES - 1);
                            nextShowPrice = price[selIdx];
                        end else begin
                            vendNext   = sel;
                            nextCredit = creditLeft;
                            if (creditLeft != '0) nextState = CHANGE;
                        end
                    end
                end else if (restock) begin
                    restockNow = 1'b1;
                end
            end
            SHOW: begin
                rejectNext = (coin != '0);
                if (cancel)                nextState = (credit != '0) ? CHANGE : IDLE;
                else if (coin != '0)       nextState = IDLE;
                else if (showCnt == '0)    nextState = IDLE;
                else                       nextShowCnt = showCnt - SHOW_W'(1);
            end
            CHANGE: begin
                rejectNext = (coin != '0);
                if (change_valid && change_ready) begin
                    nextCredit = creditPaid;
                    if (creditPaid == '0) nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        dispNext        = (nextState == SHOW) ? nextShowPrice : nextCredit;
        changeValidNext = (nextState == CHANGE);
        changeCoinNext  = changeValidNext ? greedyCoin(nextCredit) : 6'b0;
        for (int i = 0; i < N_SLOTS; i++) begin
            greenNext[i] = (stock[i] != '0) && (credit >= price[i]);
            redNext[i]   = (stock[i] == '0);
        end
    end
endmodule

// File: doc/vend_core_param.md
Name: vend_core_param

Overview:
- Parametrised vending-machine controller core: credit accumulation, price lookup, per-slot stock tracking, dispense pulses and coin-by-coin change return over a valid/ready handshake.
- Successor to the fixed 9-slot machine, with configurable slot count, credit width and stock depth.
- Sits between debounced button/coin pulses and the 7-segment and LED drivers. `disp_value` feeds the existing number-to-7SD path.

Parameters:
- N_SLOTS, 9, number of product slots.
- CREDIT_W, 12, width of credit and price values, in cents.
- MAX_CREDIT, 2000, maximum credit in cents; any coin that would exceed it is rejected.
- STOCK_W, 4, width of each per-slot stock counter.
- STOCK_INIT, 5, stock loaded into every slot at reset and on restock.
- SHOW_CYCLES, 8, number of cycles a price is shown after an underfunded selection.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- sel, in, N_SLOTS, one-cycle slot-select pulses; must be one-hot to be valid.
- coin, in, 6, one-cycle coin pulses: bit0 5c, bit1 10c, bit2 25c, bit3 50c, bit4 100c, bit5 500c.
- cancel, in, 1, one-cycle pulse requesting return of all credit.
- restock, in, 1, one-cycle pulse that reloads every slot to STOCK_INIT.
- price_flat, in, N_SLOTS*CREDIT_W, price of slot i in bits [i*CREDIT_W +: CREDIT_W]; static, multiple of 5.
- change_ready, in, 1, coin hopper accepts the presented coin.
- change_valid, out, 1, a change coin is being presented.
- change_coin, out, 6, one-hot coin code, same bit order as `coin`.
- dispense, out, N_SLOTS, one-cycle vend pulse per slot.
- led_green, out, N_SLOTS, slot is affordable and in stock.
- led_red, out, N_SLOTS, slot is sold out.
- coin_reject, out, 1, one-cycle pulse when a coin is refused.
- credit, out, CREDIT_W, current credit.
- disp_value, out, CREDIT_W, value to display.

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - state IDLE, credit=0, every stock=STOCK_INIT.
  - dispense, coin_reject, change_valid and change_coin are 0.
  - disp_value=0.
  - LEDs are recomputed on the next cycle.
  - rst overrides every other input, including mid-CHANGE: the pending change is lost.
- All outputs are registered. Every response appears the cycle after the input is sampled.
- FSM states: IDLE, SHOW, CHANGE.
- Event priority in IDLE: cancel > coin > sel > restock. Lower-priority events in the same cycle are dropped, not queued.
- Coin handling in IDLE:
  - Valid only if exactly one coin bit is set.
  - If credit+value <= MAX_CREDIT, credit increases by value.
  - Otherwise, or if multiple bits are set, coin_reject pulses and credit is unchanged.
- Coins arriving in SHOW or CHANGE: coin_reject pulses and credit is unchanged.
- sel handling in IDLE: non-one-hot sel is ignored. For slot i:
  - stock[i]==0: no action (led_red is already set).
  - credit < price[i]: go to SHOW. disp_value=price[i] for SHOW_CYCLES cycles, then return to IDLE. A cancel or coin during SHOW aborts SHOW immediately; the coin is then rejected.
  - credit >= price[i]:
    - dispense[i] pulses for 1 cycle, stock[i] decrements, credit -= price[i].
    - If the new credit > 0, go to CHANGE; otherwise stay in IDLE.
- cancel in IDLE or SHOW: if credit > 0 go to CHANGE, else no action.
- CHANGE state:
  - Present the greedy largest coin <= credit from {500,100,50,25,10,5}: change_valid=1, change_coin one-hot.
  - On change_valid && change_ready, credit drops by that coin; the next coin is presented the following cycle.
  - change_valid must hold stable until ready.
  - When credit reaches 0, go to IDLE with change_valid=0.
  - sel, coin and restock are ignored in CHANGE, except that coins are rejected.
- restock is honoured only in IDLE with no higher-priority event. It sets all stocks to STOCK_INIT.
- Stock counters never wrap; a zero stock blocks the vend.
- LEDs are computed every cycle:
  - led_green[i] = (stock[i] != 0) && (credit >= price[i]).
  - led_red[i] = (stock[i] == 0).
- disp_value shows credit in IDLE and CHANGE, and price[i] in SHOW.
- Arithmetic uses CREDIT_W-bit unsigned values. The MAX_CREDIT check is done at CREDIT_W+1 bits so the sum cannot overflow.

Test Plan:
- Reset, then sel slot0 (price 125) with credit 0 -> SHOW; disp_value=125 for 8 cycles, then disp_value=0; no dispense.
- 100c, 25c, 10c, then sel slot0 -> credit reaches 135; dispense[0] pulses once; stock0 goes 5->4; CHANGE presents 10c; with ready=1 credit ends at 0 and state returns to IDLE.
- 500c, then cancel, with change_ready low for 3 cycles -> change_valid held with coin=500 unchanged; after ready, credit=0.
- Insert 500c four times (credit 2000), then another 5c -> coin_reject pulses; credit stays 2000. Coin bits 0 and 1 set together -> rejected.
- Vend slot2 (price 5) five times -> led_red[2]=1; a sixth sel produces no dispense. restock -> stock2=5 and led_red[2]=0.
- Assert rst mid-CHANGE with credit 35 -> next cycle credit=0, change_valid=0, state IDLE, stocks reloaded.
